// File: rtl/l1_pkg.sv
// Shared types and helpers for the L1 read-port group.
// Holds the port FSM state encoding and the same-stream increment width rule.
package l1_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_EVAL  = 2'd1,
    S_PART  = 2'd2
  } state_e;

  // Width that holds the sum of every lower port's length at its maximum.
  function automatic int inc_width(input int np, input int ml);
    return $clog2(np * ml + 1);
  endfunction

endpackage

// File: rtl/l1_rd_inc.sv
// Same-stream length summation over lower-numbered ports, plus the
// cacheline-carry and discard decision for one captured request.
module l1_rd_inc #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = 6,
  parameter int nports       = 8,
  parameter int portid       = 0,
  parameter int ptr_width    = 8,
  parameter int cl_size      = 8,
  parameter int clofs_width  = 3,
  parameter int len_width    = 1,
  parameter int inc_w        = 4
) (
  input  logic [nstrms_width-1:0]        sid_i,
  input  logic [len_width-1:0]           len_i,
  input  logic [nports-1:0]              acts_i,
  input  logic [nports*nstrms_width-1:0] sids_i,
  input  logic [nports*len_width-1:0]    lens_i,
  input  logic [nstrms*ptr_width-1:0]    ptrs_i,
  input  logic [nstrms-1:0]              rst_end_i,
  input  logic [nstrms-1:0]              l1_end_i,
  input  logic [nstrms-1:0]              single_v_i,
  output logic [ptr_width-1:0]           ptr_o,
  output logic [inc_w-1:0]               inc_o,
  output logic                           dsc_o
);

  // Offset sum never exceeds three cachelines, so two spare bits suffice.
  localparam int SW = clofs_width + 2;

  logic [SW-1:0] ofs_sum;
  logic          carry;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    inc_o = '0;
    for (int j = 0; j < nports; j++) begin
      if (j < portid && acts_i[j] &&
          sids_i[j*nstrms_width +: nstrms_width] == sid_i) begin
        inc_o = inc_o + inc_w'(lens_i[j*len_width +: len_width]);
      end
    end
  end

  assign ptr_o = ptrs_i[sid_i*ptr_width +: ptr_width];

  // offset + inc + len - 1 >= cl_size, rewritten to avoid underflow at len 0.
  assign ofs_sum = SW'(ptr_o[clofs_width-1:0]) + SW'(inc_o) + SW'(len_i);
  assign carry   = ofs_sum > SW'(cl_size);

  assign dsc_o = l1_end_i[sid_i]
               | (rst_end_i[sid_i] & single_v_i[sid_i] & carry)
               | (len_i == '0);

endmodule

// File: rtl/l1_rd_port_grp.sv
// One L1 read port: s1 capture, pointer evaluation, and an eager fork into
// an in-order address channel (with discards) and a pointer-update channel.
module l1_rd_port_grp
  import l1_pkg::*;
#(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int nports       = 8,
  parameter int portid       = 0,
  parameter int ptr_width    = 8,
  parameter int cl_size      = 8,
  parameter int clofs_width  = $clog2(cl_size),
  parameter int max_len      = 1,
  parameter int len_width    = $clog2(max_len + 1),
  parameter int cnt_width    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [nstrms-1:0]              i_rst_end,
  input  logic [nstrms-1:0]              i_l1_end,
  input  logic [nstrms-1:0]              i_single_v,
  input  logic                           i_rd_v,
  output logic                           i_rd_r,
  input  logic [nstrms_width-1:0]        i_rd_sid,
  input  logic [len_width-1:0]           i_rd_len,
  input  logic [nports-1:0]              i_rd_acts,
  input  logic [nports*nstrms_width-1:0] i_rd_sids,
  input  logic [nports*len_width-1:0]    i_rd_lens,
  input  logic [nstrms*ptr_width-1:0]    i_ptrs,
  output logic                           o_rd_act,
  output logic                           o_addr_v,
  input  logic                           o_addr_r,
  output logic [ptr_width-1:0]           o_addr_ptr,
  output logic [nstrms_width-1:0]        o_addr_sid,
  output logic [len_width-1:0]           o_addr_len,
  output logic                           o_addr_dsc,
  output logic [nstrms-1:0]              o_req_v,
  input  logic [nstrms-1:0]              o_req_r,
  output logic [len_width-1:0]           o_req_len,
  output logic [cnt_width-1:0]           o_dsc_cnt
);

  localparam int inc_w = inc_width(nports, max_len);

  state_e state_q, state_d;

  logic [nstrms_width-1:0]        s1_sid_q;
  logic [len_width-1:0]           s1_len_q;
  logic [nports-1:0]              s1_acts_q;
  logic [nports*nstrms_width-1:0] s1_sids_q;
  logic [nports*len_width-1:0]    s1_lens_q;

  logic [ptr_width-1:0] ev_ptr;
  logic [inc_w-1:0]     ev_inc;
  logic                 ev_dsc;

  logic [ptr_width-1:0] hold_ptr_q;
  logic [inc_w-1:0]     hold_inc_q;
  logic                 hold_dsc_q;
  logic                 hold_a_q;

  logic [ptr_width-1:0] eff_ptr;
  logic [inc_w-1:0]     eff_inc;
  logic                 eff_dsc;
  logic [ptr_width-1:0] a_ptr_d;

  logic                    a_v_q, a_dsc_q;
  logic [ptr_width-1:0]    a_ptr_q;
  logic [nstrms_width-1:0] a_sid_q;
  logic [len_width-1:0]    a_len_q;

  logic                    b_v_q;
  logic [nstrms_width-1:0] b_sid_q;
  logic [len_width-1:0]    b_len_q;

  logic [cnt_width-1:0] cnt_q;

  logic s1_v, capture, a_free, b_free;
  logic a_ld, b_ld, fire, hold_en;

  l1_rd_inc #(
    .nstrms       (nstrms),
    .nstrms_width (nstrms_width),
    .nports       (nports),
    .portid       (portid),
    .ptr_width    (ptr_width),
    .cl_size      (cl_size),
    .clofs_width  (clofs_width),
    .len_width    (len_width),
    .inc_w        (inc_w)
  ) u_inc (
    .sid_i      (s1_sid_q),
    .len_i      (s1_len_q),
    .acts_i     (s1_acts_q),
    .sids_i     (s1_sids_q),
    .lens_i     (s1_lens_q),
    .ptrs_i     (i_ptrs),
    .rst_end_i  (i_rst_end),
    .l1_end_i   (i_l1_end),
    .single_v_i (i_single_v),
    .ptr_o      (ev_ptr),
    .inc_o      (ev_inc),
    .dsc_o      (ev_dsc)
  );

  assign s1_v    = (state_q != S_EMPTY);
  assign a_free  = ~a_v_q | o_addr_r;
  assign b_free  = ~b_v_q | o_req_r[b_sid_q];
  assign i_rd_r  = ~s1_v | fire;
  assign capture = i_rd_v & i_rd_r;

  // FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (capture) state_d = S_EVAL;
      S_EVAL: begin
        if (fire)         state_d = capture ? S_EVAL : S_EMPTY;
        else if (hold_en) state_d = S_PART;
      end
      S_PART:  if (fire) state_d = capture ? S_EVAL : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM: branch loads and retire. A partial load only happens for dsc=0,
  // since a discard needs branch A alone.
  always_comb begin
    a_ld    = 1'b0;
    b_ld    = 1'b0;
    fire    = 1'b0;
    hold_en = 1'b0;
    case (state_q)
      S_EVAL: begin
        a_ld    = a_free;
        b_ld    = ~ev_dsc & b_free;
        fire    = a_ld & (b_ld | ev_dsc);
        hold_en = ~fire & (a_ld | b_ld);
      end
      S_PART: begin
        a_ld = ~hold_a_q & a_free;
        b_ld = hold_a_q & b_free;
        fire = a_ld | b_ld;
      end
      default: ;
    endcase
  end

  assign eff_ptr = (state_q == S_PART) ? hold_ptr_q : ev_ptr;
  assign eff_inc = (state_q == S_PART) ? hold_inc_q : ev_inc;
  assign eff_dsc = (state_q == S_PART) ? hold_dsc_q : ev_dsc;
  assign a_ptr_d = eff_dsc ? '0 : eff_ptr + ptr_width'(eff_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sid_q  <= '0;
      s1_len_q  <= '0;
      s1_acts_q <= '0;
      s1_sids_q <= '0;
      s1_lens_q <= '0;
    end else if (capture) begin
      s1_sid_q  <= i_rd_sid;
      s1_len_q  <= i_rd_len;
      s1_acts_q <= i_rd_acts;
      s1_sids_q <= i_rd_sids;
      s1_lens_q <= i_rd_lens;
    end
  end

  // Snapshot taken when the first branch loads; the second reuses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_ptr_q <= '0;
      hold_inc_q <= '0;
      hold_dsc_q <= 1'b0;
      hold_a_q   <= 1'b0;
    end else if (hold_en) begin
      hold_ptr_q <= ev_ptr;
      hold_inc_q <= ev_inc;
      hold_dsc_q <= ev_dsc;
      hold_a_q   <= a_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_v_q   <= 1'b0;
      a_ptr_q <= '0;
      a_sid_q <= '0;
      a_len_q <= '0;
      a_dsc_q <= 1'b0;
    end else if (a_ld) begin
      a_v_q   <= 1'b1;
      a_ptr_q <= a_ptr_d;
      a_sid_q <= s1_sid_q;
      a_len_q <= s1_len_q;
      a_dsc_q <= eff_dsc;
    end else if (o_addr_r) begin
      a_v_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_v_q   <= 1'b0;
      b_sid_q <= '0;
      b_len_q <= '0;
    end else if (b_ld) begin
      b_v_q   <= 1'b1;
      b_sid_q <= s1_sid_q;
      b_len_q <= s1_len_q;
    end else if (o_req_r[b_sid_q]) begin
      b_v_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (a_v_q & o_addr_r & a_dsc_q & ~&cnt_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    o_req_v          = '0;
    o_req_v[b_sid_q] = b_v_q;
  end

  assign o_rd_act   = fire;
  assign o_addr_v   = a_v_q;
  assign o_addr_ptr = a_ptr_q;
  assign o_addr_sid = a_sid_q;
  assign o_addr_len = a_len_q;
  assign o_addr_dsc = a_dsc_q;
  assign o_req_len  = b_len_q;
  assign o_dsc_cnt  = cnt_q;

endmodule

// File: tb/tb_l1_rd_port_grp.sv
// Directed bench for l1_rd_port_grp (portid 3, max_len 2, 16-entry lines,
// 3-bit discard counter): vector table plus multi-cycle corner sequences.
module tb_l1_rd_port_grp;
  import l1_pkg::*;

  logic         clk, reset;
  logic [63:0]  rst_end, l1_end, single_v;
  logic         rd_v, rd_r;
  logic [5:0]   rd_sid;
  logic [1:0]   rd_len;
  logic [7:0]   rd_acts;
  logic [47:0]  rd_sids;
  logic [15:0]  rd_lens;
  logic [511:0] ptrs;
  logic         rd_act, addr_v, addr_r, addr_dsc;
  logic [7:0]   addr_ptr;
  logic [5:0]   addr_sid;
  logic [1:0]   addr_len;
  logic [63:0]  req_v, req_r;
  logic [1:0]   req_len;
  logic [2:0]   dsc_cnt;

  l1_rd_port_grp #(
    .nstrms(64), .nports(8), .portid(3), .ptr_width(8),
    .cl_size(16), .max_len(2), .cnt_width(3)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rst_end(rst_end), .i_l1_end(l1_end), .i_single_v(single_v),
    .i_rd_v(rd_v), .i_rd_r(rd_r), .i_rd_sid(rd_sid), .i_rd_len(rd_len),
    .i_rd_acts(rd_acts), .i_rd_sids(rd_sids), .i_rd_lens(rd_lens),
    .i_ptrs(ptrs), .o_rd_act(rd_act),
    .o_addr_v(addr_v), .o_addr_r(addr_r), .o_addr_ptr(addr_ptr),
    .o_addr_sid(addr_sid), .o_addr_len(addr_len), .o_addr_dsc(addr_dsc),
    .o_req_v(req_v), .o_req_r(req_r), .o_req_len(req_len),
    .o_dsc_cnt(dsc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sid;
    logic [1:0]  len;
    logic [7:0]  acts;
    logic [47:0] sids;
    logic [15:0] lens;
    logic [7:0]  ptr;
    logic        l1e, rste, sgl;
    logic [7:0]  e_ptr;
    logic        e_dsc;
  } vec_t;

  typedef struct {
    logic [5:0] sid;
    logic [7:0] ptr;
    logic       dsc;
    logic [1:0] len;
    int         cyc;
  } hs_t;

  vec_t vt[14];
  hs_t  aq[$];
  hs_t  rq[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, exp_cnt = 0, act_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor, sampled mid-cycle where inputs and outputs are stable.
  always @(negedge clk) begin
    if (!reset) begin
      if (addr_v && addr_r) aq.push_back('{addr_sid, addr_ptr, addr_dsc, addr_len, cyc});
      for (int s = 0; s < 64; s++)
        if (req_v[s] && req_r[s]) rq.push_back('{6'(s), 8'h0, 1'b0, req_len, cyc});
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] s8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [15:0] l8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {2'(a7), 2'(a6), 2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic drive(input int sid, input int len, input logic [7:0] ptr);
    rd_sid  = 6'(sid);
    rd_len  = 2'(len);
    rd_acts = '0;
    rd_sids = '0;
    rd_lens = '0;
    ptrs[sid*8 +: 8] = ptr;
    rd_v = 1'b1;
  endtask

  function automatic int sat_inc(input int c);
    return (c == 7) ? 7 : c + 1;
  endfunction

  initial begin
    // sid len acts sids lens ptr l1e rste sgl | exp ptr, exp dsc
    vt[0]  = '{6'd5,  2'd1, 8'h07, s8(5,5,5,0,0,0,0,0),    l8(1,1,1,0,0,0,0,0), 8'h10, 1'b0, 1'b0, 1'b0, 8'h13, 1'b0};
    vt[1]  = '{6'd2,  2'd2, 8'h01, s8(2,0,0,0,0,0,0,0),    l8(2,0,0,0,0,0,0,0), 8'h0D, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
    vt[2]  = '{6'd2,  2'd2, 8'h01, s8(2,0,0,0,0,0,0,0),    l8(2,0,0,0,0,0,0,0), 8'h0D, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b0};
    vt[3]  = '{6'd9,  2'd2, 8'hFF, s8(9,9,9,9,9,9,9,9),    l8(2,2,2,2,2,2,2,2), 8'h20, 1'b0, 1'b0, 1'b0, 8'h26, 1'b0};
    vt[4]  = '{6'd4,  2'd1, 8'h07, s8(4,9,4,0,0,0,0,0),    l8(1,2,2,0,0,0,0,0), 8'hFE, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0};
    vt[5]  = '{6'd11, 2'd0, 8'h00, s8(0,0,0,0,0,0,0,0),    l8(0,0,0,0,0,0,0,0), 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[6]  = '{6'd7,  2'd1, 8'h00, s8(0,0,0,0,0,0,0,0),    l8(0,0,0,0,0,0,0,0), 8'h33, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[7]  = '{6'd12, 2'd1, 8'h02, s8(12,12,12,0,0,0,0,0), l8(1,2,1,0,0,0,0,0), 8'h30, 1'b0, 1'b0, 1'b0, 8'h32, 1'b0};
    vt[8]  = '{6'd13, 2'd1, 8'h00, s8(0,0,0,0,0,0,0,0),    l8(0,0,0,0,0,0,0,0), 8'h31, 1'b0, 1'b1, 1'b1, 8'h31, 1'b0};
    vt[9]  = '{6'd14, 2'd1, 8'h00, s8(0,0,0,0,0,0,0,0),    l8(0,0,0,0,0,0,0,0), 8'h1F, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0};
    vt[10] = '{6'd14, 2'd2, 8'h00, s8(0,0,0,0,0,0,0,0),    l8(0,0,0,0,0,0,0,0), 8'h1F, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
    vt[11] = '{6'd15, 2'd2, 8'h02, s8(0,15,0,0,0,0,0,0),   l8(0,2,0,0,0,0,0,0), 8'h0C, 1'b0, 1'b1, 1'b1, 8'h0E, 1'b0};
    vt[12] = '{6'd15, 2'd2, 8'h03, s8(15,15,0,0,0,0,0,0),  l8(2,2,0,0,0,0,0,0), 8'h0C, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
    vt[13] = '{6'd16, 2'd1, 8'h18, s8(0,0,0,16,16,0,0,0),  l8(0,0,0,2,2,0,0,0), 8'h08, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0};

    clk = 1'b0; reset = 1'b1;
    rst_end = '0; l1_end = '0; single_v = '0;
    rd_v = 1'b0; rd_sid = '0; rd_len = '0; rd_acts = '0; rd_sids = '0; rd_lens = '0;
    ptrs = '0; addr_r = 1'b1; req_r = '1;
    repeat (2) step();
    reset = 1'b0;

    check("rst_addr_v", addr_v, 0);
    check("rst_req_v", req_v, 0);
    check("rst_rd_r", rd_r, 1);
    check("rst_rd_act", rd_act, 0);
    check("rst_dsc_cnt", dsc_cnt, 0);
    check("rst_state", dut.state_q, S_EMPTY);

    // Single requests with all readies high.
    for (int i = 0; i < 14; i++) begin
      ptrs[int'(vt[i].sid)*8 +: 8] = vt[i].ptr;
      l1_end[vt[i].sid]   = vt[i].l1e;
      rst_end[vt[i].sid]  = vt[i].rste;
      single_v[vt[i].sid] = vt[i].sgl;
      rd_sid = vt[i].sid; rd_len = vt[i].len; rd_acts = vt[i].acts;
      rd_sids = vt[i].sids; rd_lens = vt[i].lens; rd_v = 1'b1;
      step();
      rd_v = 1'b0;
      check($sformatf("v%0d_rd_act", i), rd_act, 1);
      step();
      check($sformatf("v%0d_addr_v", i), addr_v, 1);
      check($sformatf("v%0d_addr_sid", i), addr_sid, vt[i].sid);
      check($sformatf("v%0d_addr_len", i), addr_len, vt[i].len);
      check($sformatf("v%0d_addr_ptr", i), addr_ptr, vt[i].e_ptr);
      check($sformatf("v%0d_addr_dsc", i), addr_dsc, vt[i].e_dsc);
      check($sformatf("v%0d_req_v", i), req_v, vt[i].e_dsc ? 64'd0 : (64'd1 << vt[i].sid));
      if (!vt[i].e_dsc) check($sformatf("v%0d_req_len", i), req_len, vt[i].len);
      check($sformatf("v%0d_dsc_cnt", i), dsc_cnt, exp_cnt);
      if (vt[i].e_dsc) exp_cnt = sat_inc(exp_cnt);
      l1_end[vt[i].sid] = 1'b0; rst_end[vt[i].sid] = 1'b0; single_v[vt[i].sid] = 1'b0;
      step();
    end
    check("vec_dsc_cnt", dsc_cnt, exp_cnt);

    // Discard on sid 7 returns ahead of sid 8 on the address channel.
    aq.delete(); rq.delete();
    addr_r = 1'b0; l1_end[7] = 1'b1;
    drive(7, 1, 8'h33); step();
    drive(8, 1, 8'h58); step();
    rd_v = 1'b0;
    check("ord_a_dsc", addr_dsc, 1);
    check("ord_a_sid", addr_sid, 7);
    check("ord_req_v_idle", req_v, 0);
    step();
    addr_r = 1'b1;
    repeat (3) step();
    l1_end[7] = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    check("ord_n_addr", aq.size(), 2);
    check("ord_n_req", rq.size(), 1);
    if (aq.size() == 2) begin
      check("ord0_sid", aq[0].sid, 7);
      check("ord0_dsc", aq[0].dsc, 1);
      check("ord0_ptr", aq[0].ptr, 0);
      check("ord1_sid", aq[1].sid, 8);
      check("ord1_dsc", aq[1].dsc, 0);
      check("ord1_ptr", aq[1].ptr, 8'h58);
    end
    if (rq.size() == 1) check("ord_req_sid", rq[0].sid, 8);
    check("ord_dsc_cnt", dsc_cnt, exp_cnt);

    // Request branch stalled: address goes first, request fires on release.
    req_r = '0;
    drive(19, 1, 8'h60); step();
    drive(20, 2, 8'h44); step();
    rd_v = 1'b0;
    check("pb_rd_act_stall", rd_act, 0);
    check("pb_rd_r_stall", rd_r, 0);
    step();
    check("pb_state", dut.state_q, S_PART);
    check("pb_addr_v", addr_v, 1);
    check("pb_addr_sid", addr_sid, 20);
    check("pb_addr_ptr", addr_ptr, 8'h44);
    check("pb_req_v_old", req_v, 64'd1 << 19);
    ptrs[20*8 +: 8] = 8'h99;
    step();
    check("pb_state2", dut.state_q, S_PART);
    check("pb_addr_v_done", addr_v, 0);
    ptrs[20*8 +: 8] = 8'h11;
    step();
    req_r = '1;
    #1;
    check("pb_rd_act_rel", rd_act, 1);
    step();
    check("pb_req_v", req_v, 64'd1 << 20);
    check("pb_req_len", req_len, 2);
    check("pb_state_end", dut.state_q, S_EMPTY);
    step();

    // Address branch stalled: held pointer and dsc survive input changes.
    addr_r = 1'b0;
    drive(30, 1, 8'h70); step();
    drive(21, 1, 8'h50); step();
    rd_v = 1'b0;
    step();
    check("pa_state", dut.state_q, S_PART);
    check("pa_req_v", req_v, 64'd1 << 21);
    check("pa_addr_sid_old", addr_sid, 30);
    ptrs[21*8 +: 8] = 8'h77;
    l1_end[21] = 1'b1;
    step();
    addr_r = 1'b1;
    #1;
    check("pa_rd_act_rel", rd_act, 1);
    step();
    check("pa_addr_sid", addr_sid, 21);
    check("pa_addr_ptr", addr_ptr, 8'h50);
    check("pa_addr_dsc", addr_dsc, 0);
    step();
    l1_end[21] = 1'b0;

    // Sixteen back-to-back requests.
    aq.delete(); rq.delete();
    act_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(i, 1, 8'(8'h80 + i));
      step();
      if (rd_act && rd_r) act_cnt++;
    end
    rd_v = 1'b0;
    repeat (3) step();
    check("b2b_rd_act", act_cnt, 16);
    check("b2b_n_addr", aq.size(), 16);
    check("b2b_n_req", rq.size(), 16);
    if (aq.size() == 16 && rq.size() == 16) begin
      check("b2b_addr_span", aq[15].cyc - aq[0].cyc, 15);
      check("b2b_req_span", rq[15].cyc - rq[0].cyc, 15);
      for (int i = 0; i < 16; i++) begin
        check($sformatf("b2b%0d_addr_sid", i), aq[i].sid, i);
        check($sformatf("b2b%0d_addr_ptr", i), aq[i].ptr, 8'h80 + i);
        check($sformatf("b2b%0d_req_sid", i), rq[i].sid, i);
      end
    end

    // Discard counter saturates at all-ones.
    for (int k = 0; k < 3; k++) begin
      drive(50, 0, 8'h10);
      step();
      rd_v = 1'b0;
      repeat (2) step();
      exp_cnt = sat_inc(exp_cnt);
    end
    check("sat_dsc_cnt", dsc_cnt, exp_cnt);

    // Reset while partially forked drops everything.
    req_r = '0;
    drive(40, 1, 8'h20); step();
    drive(41, 1, 8'h21); step();
    rd_v = 1'b0;
    step();
    check("mr_pre_state", dut.state_q, S_PART);
    reset = 1'b1;
    step();
    check("mr_addr_v", addr_v, 0);
    check("mr_req_v", req_v, 0);
    check("mr_dsc_cnt", dsc_cnt, 0);
    check("mr_rd_r", rd_r, 1);
    check("mr_state", dut.state_q, S_EMPTY);
    reset = 1'b0;
    req_r = '1;
    repeat (3) step();
    check("mr_quiet_addr", addr_v, 0);
    check("mr_quiet_req", req_v, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
